regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/slc3_rf_pkg.sv | 14 +
 rtl/rr_arb2.sv | 38 +++
 rtl/regfile_wb_ctrl.sv | 90 +++++++++
 tb/tb_regfile_wb_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_rf_pkg.sv
// Shared types for the register-file writeback controller: register index,
// register count and the writeback source used as the arbitration pointer.
package slc3_rf_pkg;

  localparam int unsigned NUM_REGS = 8;

  typedef logic [2:0] reg_idx_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with combinational grants and a registered
// pointer that only advances after a contended cycle.
module rr_arb2
  import slc3_rf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  wb_src_t ptr;
  wb_src_t ptr_next;

  always_ff @(posedge clk) begin
    if (reset) ptr <= WB_ALU;
    else       ptr <= ptr_next;
  end

  // Under contention the loser becomes the preferred requester next time.
  always_comb begin
    ptr_next = ptr;
    if (req_alu && req_mem)
      ptr_next = (ptr == WB_ALU) ? WB_MEM : WB_ALU;
  end

  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (!reset) begin
      if (req_alu && (!req_mem || ptr == WB_ALU)) gnt_alu = 1'b1;
      else if (req_mem)                             gnt_mem = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU/MEM writebacks into a
// registered write port and keeps a pending-write scoreboard.
// Optional macro RF_WB_BYPASS_EN releases srX_busy in the write cycle.
module regfile_wb_ctrl
  import slc3_rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [2:0]            alu_dr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [2:0]            mem_dr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  input  logic                  issue_valid,
  input  logic [2:0]            issue_dr,
  input  logic [2:0]            sr1,
  input  logic [2:0]            sr2,
  output logic                  sr1_busy,
  output logic                  sr2_busy,
  output logic                  rf_ld,
  output logic [2:0]            rf_dr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic                  alu_hs;
  logic                  mem_hs;
  logic [NUM_REGS-1:0]   busy_next;
  reg_idx_t              sel_dr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_alu (alu_valid),
    .req_mem (mem_valid),
    .gnt_alu (alu_ready),
    .gnt_mem (mem_ready)
  );

  assign alu_hs = alu_valid & alu_ready;
  assign mem_hs = mem_valid & mem_ready;

  always_comb begin
    sel_dr   = alu_hs ? alu_dr   : mem_dr;
    sel_data = alu_hs ? alu_data : mem_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_ld  <= 1'b0;
      rf_dr  <= '0;
      rf_din <= '0;
    end else begin
      rf_ld <= alu_hs | mem_hs;
      if (alu_hs | mem_hs) begin
        rf_dr  <= sel_dr;
        rf_din <= sel_data;
      end
    end
  end

  // Clear is applied before set so an issue on the written index wins.
  always_comb begin
    busy_next = busy_vec;
    if (rf_ld)       busy_next[rf_dr]    = 1'b0;
    if (issue_valid) busy_next[issue_dr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= busy_next;
  end

  always_comb begin
`ifdef RF_WB_BYPASS_EN
    sr1_busy = busy_vec[sr1] & ~(rf_ld & (rf_dr == sr1));
    sr2_busy = busy_vec[sr2] & ~(rf_ld & (rf_dr == sr2));
`else
    sr1_busy = busy_vec[sr1];
    sr2_busy = busy_vec[sr2];
`endif
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed scenarios followed by
// constrained-random traffic, checked against a behavioural model.
module tb_regfile_wb_ctrl;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid, issue_valid;
  logic [2:0]    alu_dr, mem_dr, issue_dr, sr1, sr2;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, sr1_busy, sr2_busy, rf_ld;
  logic [2:0]    rf_dr;
  logic [DW-1:0] rf_din;
  logic [7:0]    busy_vec;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dr(alu_dr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_dr(issue_dr),
    .sr1(sr1), .sr2(sr2), .sr1_busy(sr1_busy), .sr2_busy(sr2_busy),
    .rf_ld(rf_ld), .rf_dr(rf_dr), .rf_din(rf_din), .busy_vec(busy_vec)
  );

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model state
  typedef struct {
    int unsigned   c;
    logic [2:0]    dr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t q[$];

  bit         alu_turn_m = 1'b1;
  bit         busy_m[8];
  bit         wr_pend_m = 1'b0;
  logic [2:0] wr_dr_m = '0;
  bit         exp_ga, exp_gm;
  bit         alu_hs_m = 1'b0, mem_hs_m = 1'b0, both_s = 1'b0, rst_s = 1'b1, iss_s = 1'b0;
  bit         rst_prev = 1'b1;
  logic [2:0] iss_dr_s = '0, hs_dr_s = '0;
  logic [7:0] bv;
  logic [DW-1:0] last_din = '0;
  logic [2:0]    last_dr = '0;

  function automatic bit sr_busy_exp(input logic [2:0] s);
`ifdef RF_WB_BYPASS_EN
    return busy_m[s] && !(wr_pend_m && wr_dr_m == s);
`else
    return busy_m[s];
`endif
  endfunction

  // Model: grant decision, scoreboard state and push of expected writes
  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_ga = !reset && alu_valid && (!mem_valid || alu_turn_m);
      exp_gm = !reset && mem_valid && !exp_ga;
      chk("alu_ready", alu_ready, exp_ga);
      chk("mem_ready", mem_ready, exp_gm);
      chk("ready_exclusive", alu_ready & mem_ready, 0);
      for (int i = 0; i < 8; i++) bv[i] = busy_m[i];
      chk("busy_vec", busy_vec, bv);
      chk("sr1_busy", sr1_busy, sr_busy_exp(sr1));
      chk("sr2_busy", sr2_busy, sr_busy_exp(sr2));
      alu_hs_m = exp_ga;
      mem_hs_m = exp_gm;
      both_s   = alu_valid && mem_valid;
      rst_s    = reset;
      iss_s    = issue_valid;
      iss_dr_s = issue_dr;
      hs_dr_s  = exp_ga ? alu_dr : mem_dr;
      if (exp_ga)      q.push_back('{cyc, alu_dr, alu_data});
      else if (exp_gm) q.push_back('{cyc, mem_dr, mem_data});
    end
  end

  always @(posedge clk) begin
    if (rst_s) begin
      for (int i = 0; i < 8; i++) busy_m[i] = 1'b0;
      alu_turn_m = 1'b1;
      wr_pend_m  = 1'b0;
    end else begin
      if (wr_pend_m) busy_m[wr_dr_m] = 1'b0;
      if (iss_s)     busy_m[iss_dr_s] = 1'b1;
      if (both_s)    alu_turn_m = !alu_hs_m;
      wr_pend_m = alu_hs_m || mem_hs_m;
      if (wr_pend_m) wr_dr_m = hs_dr_s;
    end
    rst_prev = rst_s;
    alu_hs_m = 1'b0;
    mem_hs_m = 1'b0;
    cyc++;
  end

  // Monitor: write port against the expected-write queue
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_prev) begin
        chk("rst_rf_ld", rf_ld, 0);
        chk("rst_rf_dr", rf_dr, 0);
        chk("rst_rf_din", rf_din, 0);
        last_dr  = '0;
        last_din = '0;
        while (q.size() > 0 && q[0].c < cyc) void'(q.pop_front());
      end else if (rf_ld) begin
        if (q.size() == 0 || q[0].c != cyc - 1) begin
          chk("rf_ld_spurious", rf_ld, 0);
        end else begin
          chk("rf_dr", rf_dr, q[0].dr);
          chk("rf_din", rf_din, q[0].data);
          last_dr  = q[0].dr;
          last_din = q[0].data;
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].c < cyc) begin
        chk("rf_ld_missing", rf_ld, 1);
        void'(q.pop_front());
      end else begin
        chk("rf_dr_hold", rf_dr, last_dr);
        chk("rf_din_hold", rf_din, last_din);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_dr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dr = '0; mem_data = '0;
    issue_valid = 1'b0; issue_dr = '0; sr1 = '0; sr2 = '0;
    step(); step();
    reset = 1'b0;

    // Single ALU writeback
    alu_valid = 1'b1; alu_dr = 3'd3; alu_data = 16'h1234;
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("single_rf_ld", rf_ld, 1);
    chk("single_rf_din", rf_din, 16'h1234);
    step(); step();

    // Contended requests right after reset alternate ALU, MEM, ALU
    reset = 1'b1; step(); reset = 1'b0;
    alu_valid = 1'b1; alu_dr = 3'd1; alu_data = 16'hAAAA;
    mem_valid = 1'b1; mem_dr = 3'd2; mem_data = 16'h5555;
    repeat (4) step();
    idle(); step(); step();

    // Scoreboard set / clear / set-wins
    issue_valid = 1'b1; issue_dr = 3'd5; sr1 = 3'd5;
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_issue5", busy_vec, 8'h20);
    step();
    mem_valid = 1'b1; mem_dr = 3'd5; mem_data = 16'hBEEF;
    step();
    mem_valid = 1'b0; issue_valid = 1'b1; issue_dr = 3'd5;
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("busy5_set_wins", busy_vec[5], 1);
    step();
    mem_valid = 1'b1; mem_dr = 3'd5; mem_data = 16'h0F0F;
    step();
    mem_valid = 1'b0;
    step(); step();

    // Write-cycle release on sr2 (bypass build only)
    issue_valid = 1'b1; issue_dr = 3'd4; sr2 = 3'd4;
    step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_dr = 3'd4; alu_data = 16'h4444;
    step();
    alu_valid = 1'b0;
    step(); step();

    // Reset right after a handshake on r7
    issue_valid = 1'b1; issue_dr = 3'd7;
    alu_valid = 1'b1; alu_dr = 3'd7; alu_data = 16'h7777;
    step();
    idle(); reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("post_reset_busy", busy_vec, 8'h00);
    alu_valid = 1'b1; alu_dr = 3'd6; alu_data = 16'h0606;
    mem_valid = 1'b1; mem_dr = 3'd6; mem_data = 16'h6060;
    #1;
    chk("post_reset_alu_first", alu_ready, 1);
    step(); step();
    idle(); step();

    // Random traffic; each requester holds its request until accepted
    repeat (3000) begin
      if (!alu_valid || alu_ready) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_dr    = 3'($urandom_range(0, 7));
        alu_data  = 16'($urandom);
      end
      if (!mem_valid || mem_ready) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_dr    = 3'($urandom_range(0, 7));
        mem_data  = 16'($urandom);
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_dr    = 3'($urandom_range(0, 7));
      sr1         = 3'($urandom_range(0, 7));
      sr2         = 3'($urandom_range(0, 7));
      reset       = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end

    reset = 1'b0;
    idle();
    step(); step(); step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
